// File: rtl/clock_div_bank_pkg.sv
// Shared defaults and helpers for the clock divider bank.
package clock_div_bank_pkg;

  // Width of one half-period count.
  localparam int CNT_W_DEFAULT = 8;

  // Half-period loaded at reset; 2 gives the legacy divide-by-4 clock.
  localparam int RESET_DIV_DEFAULT = 2;

  // Channel-select width, never narrower than one bit.
  function automatic int ch_idx_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/clock_div_channel.sv
// One divider channel: half-period counter, output toggle, staged ratio update.
module clock_div_channel
  import clock_div_bank_pkg::*;
#(
  parameter int CNT_W     = CNT_W_DEFAULT,
  parameter int RESET_DIV = RESET_DIV_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cfg_we,
  input  logic [CNT_W-1:0] cfg_div,
  input  logic             sync,
  output logic             div_clk,
  output logic             rise_en,
  output logic             pending
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] pend_val_q, pend_val_d;
  logic             pend_q, pend_d;
  logic             out_q, out_d;
  logic             rise_q, rise_d;
  logic             at_end;

  assign at_end = (cnt_q == (div_q - CNT_W'(1)));

  // Next-state: a new ratio only lands at a high-to-low toggle, on sync, or straight away when stopped.
  always_comb begin
    cnt_d      = cnt_q;
    div_d      = div_q;
    pend_val_d = pend_val_q;
    pend_d     = pend_q;
    out_d      = out_q;
    rise_d     = 1'b0;

    if (cfg_we) begin
      pend_val_d = cfg_div;
      pend_d     = 1'b1;
    end

    if (sync) begin
      cnt_d  = '0;
      out_d  = 1'b0;
      pend_d = 1'b0;
      if (cfg_we) begin
        div_d = cfg_div;
      end else if (pend_q) begin
        div_d = pend_val_q;
      end
    end else if (div_q == '0) begin
      cnt_d = '0;
      out_d = 1'b0;
      if (pend_q) begin
        div_d  = pend_val_q;
        pend_d = cfg_we;
      end
    end else if (at_end) begin
      cnt_d = '0;
      out_d = ~out_q;
      if (!out_q) begin
        rise_d = 1'b1;
      end else begin
        pend_d = 1'b0;
        if (cfg_we) begin
          div_d = cfg_div;
        end else if (pend_q) begin
          div_d = pend_val_q;
        end
      end
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Channel state register; reset drops the output immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q      <= '0;
      div_q      <= CNT_W'(RESET_DIV);
      pend_val_q <= '0;
      pend_q     <= 1'b0;
      out_q      <= 1'b0;
      rise_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      pend_val_q <= pend_val_d;
      pend_q     <= pend_d;
      out_q      <= out_d;
      rise_q     <= rise_d;
    end
  end

  assign div_clk = out_q;
  assign rise_en = rise_q;
  assign pending = pend_q;

endmodule

// File: rtl/clock_div_bank.sv
// Bank of independent clock dividers with run-time ratio writes and a common sync.
module clock_div_bank
  import clock_div_bank_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int CNT_W     = CNT_W_DEFAULT,
  parameter int RESET_DIV = RESET_DIV_DEFAULT
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          cfg_we,
  input  logic [ch_idx_w(NUM_CH)-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]              cfg_div,
  input  logic                          sync,
  output logic [NUM_CH-1:0]             div_clk,
  output logic [NUM_CH-1:0]             rise_en,
  output logic [NUM_CH-1:0]             pending
);

  logic [NUM_CH-1:0] ch_we;

  // Channel select decode; an index beyond the last channel selects nothing.
  always_comb begin
    ch_we = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_we && (int'(cfg_ch) == i)) begin
        ch_we[i] = 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clock_div_channel #(
      .CNT_W     (CNT_W),
      .RESET_DIV (RESET_DIV)
    ) u_ch (
      .clock   (clock),
      .reset   (reset),
      .cfg_we  (ch_we[g]),
      .cfg_div (cfg_div),
      .sync    (sync),
      .div_clk (div_clk[g]),
      .rise_en (rise_en[g]),
      .pending (pending[g])
    );
  end

endmodule

// File: tb/tb_clock_div_bank.sv
// Scoreboard bench: stimulus queues per-channel expectations keyed by clock edge,
// a monitor pops and compares them as the edges (or async events) arrive.
module tb_clock_div_bank;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 8;

  logic              clock = 1'b0;
  logic              reset;
  logic              cfg_we;
  logic [1:0]        cfg_ch;
  logic [CNT_W-1:0]  cfg_div;
  logic              sync;
  logic [NUM_CH-1:0] div_clk;
  logic [NUM_CH-1:0] rise_en;
  logic [NUM_CH-1:0] pending;

  typedef struct {
    int    cyc;
    int    ch;
    logic  clk;
    logic  rise;
    logic  pend;
    string tag;
  } exp_t;

  exp_t sb[$];
  int   cyc       = 0;
  int   base      = 0;
  int   checks    = 0;
  int   errors    = 0;
  bit   async_req = 1'b0;
  bit   done_req  = 1'b0;
  event async_ev;

  clock_div_bank dut (
    .clock   (clock),
    .reset   (reset),
    .cfg_we  (cfg_we),
    .cfg_ch  (cfg_ch),
    .cfg_div (cfg_div),
    .sync    (sync),
    .div_clk (div_clk),
    .rise_en (rise_en),
    .pending (pending)
  );

  // Free-running board clock.
  always #5 clock = ~clock;

  // Absolute edge counter used as the scoreboard key.
  always @(posedge clock) cyc <= cyc + 1;

  // Queue one expectation; k is the edge number after reset release, -1 for an async sample.
  task automatic pushExp(input int k, input int ch, input logic c, input logic r,
                         input logic p, input string tag);
    exp_t e;
    e.cyc  = (k < 0) ? -1 : base + k;
    e.ch   = ch;
    e.clk  = c;
    e.rise = r;
    e.pend = p;
    e.tag  = tag;
    sb.push_back(e);
  endtask

  // Ideal divider waveform: counting from a cleared channel at edge start, high in the second half of each 2d period.
  task automatic pushPattern(input int ch, input int d, input int start, input int from,
                             input int to, input logic p, input string tag);
    for (int k = from; k <= to; k++) begin
      int m;
      m = (k - start) % (2 * d);
      pushExp(k, ch, (m >= d), (m == d), p, tag);
    end
  endtask

  // Every channel fully cleared, sampled outside the clock.
  task automatic pushAsyncZeros(input string tag);
    for (int c = 0; c < NUM_CH; c++) pushExp(-1, c, 1'b0, 1'b0, 1'b0, tag);
  endtask

  // Drive one input vector so it is captured on edge e.
  task automatic applyStimulus(input int e, input logic we, input int ch, input int d,
                               input logic s);
    while (cyc != base + e - 1) @(negedge clock);
    cfg_we  = we;
    cfg_ch  = 2'(ch);
    cfg_div = CNT_W'(d);
    sync    = s;
    @(negedge clock);
    cfg_we  = 1'b0;
    sync    = 1'b0;
  endtask

  task automatic waitEdge(input int e);
    while (cyc != base + e) @(negedge clock);
  endtask

  // Pop and compare every expectation keyed to this sample point.
  task automatic checkOutput(input int key);
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == key) begin
        checks++;
        if (div_clk[sb[i].ch] !== sb[i].clk || rise_en[sb[i].ch] !== sb[i].rise ||
            pending[sb[i].ch] !== sb[i].pend) begin
          errors++;
          $display("[TB] FAIL %s ch%0d cyc=%0d: clk/rise/pend got %b%b%b want %b%b%b",
                   sb[i].tag, sb[i].ch, key, div_clk[sb[i].ch], rise_en[sb[i].ch],
                   pending[sb[i].ch], sb[i].clk, sb[i].rise, sb[i].pend);
        end
        sb.delete(i);
      end
    end
  endtask

  // Monitor: samples on the falling edge or on an async request, then reports.
  initial begin
    int key;
    forever begin
      @(negedge clock or async_ev);
      if (done_req) break;
      key = async_req ? -1 : cyc;
      checkOutput(key);
    end
    foreach (sb[i]) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s ch%0d: expectation for cyc=%0d never sampled",
               sb[i].tag, sb[i].ch, sb[i].cyc);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Stimulus and expectation generation.
  initial begin
    reset   = 1'b1;
    cfg_we  = 1'b0;
    cfg_ch  = '0;
    cfg_div = '0;
    sync    = 1'b0;

    repeat (3) @(negedge clock);
    #1 async_req = 1'b1;
    pushAsyncZeros("reset_hold");
    ->async_ev;
    #1 async_req = 1'b0;

    // Session 1: defaults, then ratio changes on channels 1..3 and a boundary write on 0.
    @(negedge clock);
    base = cyc;
    pushPattern(0, 2, 0, 1, 23, 1'b0, "s1_ch0_div4");
    pushExp(24, 0, 1'b0, 1'b0, 1'b0, "s1_ch0_bnd_wr");
    pushPattern(0, 1, 24, 25, 30, 1'b0, "s1_ch0_div2");
    pushPattern(1, 2, 0, 1, 12, 1'b0, "s1_ch1_old");
    pushPattern(1, 2, 0, 13, 15, 1'b1, "s1_ch1_pend");
    pushPattern(1, 3, 16, 16, 31, 1'b0, "s1_ch1_d3");
    pushPattern(2, 2, 0, 1, 13, 1'b0, "s1_ch2_old");
    pushPattern(2, 2, 0, 14, 15, 1'b1, "s1_ch2_pend0");
    for (int k = 16; k <= 19; k++) pushExp(k, 2, 1'b0, 1'b0, 1'b0, "s1_ch2_stop");
    pushExp(20, 2, 1'b0, 1'b0, 1'b1, "s1_ch2_pend5");
    pushPattern(2, 5, 21, 21, 41, 1'b0, "s1_ch2_d5");
    pushPattern(3, 2, 0, 1, 16, 1'b0, "s1_ch3_old");
    pushPattern(3, 2, 0, 17, 19, 1'b1, "s1_ch3_pend");
    pushPattern(3, 7, 20, 20, 48, 1'b0, "s1_ch3_d7");
    reset = 1'b0;

    applyStimulus(13, 1'b1, 1, 3, 1'b0);
    applyStimulus(14, 1'b1, 2, 0, 1'b0);
    applyStimulus(17, 1'b1, 3, 4, 1'b0);
    applyStimulus(18, 1'b1, 3, 7, 1'b0);
    applyStimulus(20, 1'b1, 2, 5, 1'b0);
    applyStimulus(24, 1'b1, 0, 1, 1'b0);
    waitEdge(56);

    // Session 2: mixed ratios, sync with a same-cycle write, then async reset mid-high.
    reset = 1'b1;
    repeat (2) @(negedge clock);
    base = cyc;
    pushPattern(0, 2, 0, 1, 3, 1'b1, "s2_ch0_pend");
    pushExp(4, 0, 1'b0, 1'b0, 1'b0, "s2_ch0_apply");
    pushPattern(0, 1, 4, 5, 8, 1'b0, "s2_ch0_d1");
    pushPattern(1, 2, 0, 1, 8, 1'b0, "s2_ch1_d2");
    pushPattern(2, 2, 0, 1, 1, 1'b0, "s2_ch2_old");
    pushPattern(2, 2, 0, 2, 3, 1'b1, "s2_ch2_pend");
    pushExp(4, 2, 1'b0, 1'b0, 1'b0, "s2_ch2_apply");
    pushPattern(2, 3, 4, 5, 8, 1'b0, "s2_ch2_d3");
    pushPattern(3, 2, 0, 1, 8, 1'b0, "s2_ch3_d2");
    for (int c = 0; c < NUM_CH; c++) pushExp(9, c, 1'b0, 1'b0, 1'b0, "s2_sync_clear");
    pushPattern(0, 1, 9, 10, 22, 1'b0, "s2_ch0_post");
    pushPattern(1, 2, 9, 10, 22, 1'b0, "s2_ch1_post");
    pushPattern(2, 3, 9, 10, 22, 1'b0, "s2_ch2_post");
    pushPattern(3, 4, 9, 10, 19, 1'b0, "s2_ch3_post");
    pushPattern(3, 4, 9, 20, 22, 1'b1, "s2_ch3_pend9");
    reset = 1'b0;

    applyStimulus(1, 1'b1, 0, 1, 1'b0);
    applyStimulus(2, 1'b1, 2, 3, 1'b0);
    applyStimulus(9, 1'b1, 3, 4, 1'b1);
    applyStimulus(20, 1'b1, 3, 9, 1'b0);
    waitEdge(22);

    #2 reset = 1'b1;
    #1 async_req = 1'b1;
    pushAsyncZeros("async_reset");
    for (int k = 23; k <= 24; k++) begin
      for (int c = 0; c < NUM_CH; c++) pushExp(k, c, 1'b0, 1'b0, 1'b0, "reset_held");
    end
    ->async_ev;
    #1 async_req = 1'b0;

    waitEdge(25);
    #1 done_req = 1'b1;
    ->async_ev;
  end

  // Hard stop if the run never reaches its summary.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
